// File: rtl/data_mem_initiator.sv
// data_mem_initiator
//   Load/store initiator for the 128x8 synchronous data memory. Accepts
//   single writes and single/burst reads on a valid/ready request channel,
//   sequences the memory strobes around its one-cycle read latency, and
//   returns read beats on a valid/ready response channel.
//
//   Optional build macro: WRITE_VERIFY_EN
//     Each write is read back and compared; a mismatch sets verifyErr
//     (sticky until reset). Without the macro verifyErr is tied low.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   reqValid/reqReady               request handshake
//   reqWrite, reqAddr, reqData      request kind, start line, write data
//   reqLen                          read beats minus 1
//   rspValid/rspReady               response handshake
//   rspData, rspLast                read data, final beat of burst
//   busy                            FSM not idle
//   verifyErr                       sticky write-verify mismatch
//   memRead, memWrite               memory enables
//   lineNumber, memIn, memOut       memory address, write data, read data
module data_mem_initiator #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [DATA_W-1:0] reqData,
  input  logic [LEN_W-1:0]  reqLen,
  output logic              rspValid,
  input  logic              rspReady,
  output logic [DATA_W-1:0] rspData,
  output logic              rspLast,
  output logic              busy,
  output logic              verifyErr,
  output logic              memRead,
  output logic              memWrite,
  output logic [ADDR_W-1:0] lineNumber,
  output logic [DATA_W-1:0] memIn,
  input  logic [DATA_W-1:0] memOut
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_CAP,
    RSP
`ifdef WRITE_VERIFY_EN
    ,
    VF_ISSUE,
    VF_CHECK
`endif
  } state_t;

  state_t state, nextState;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic [LEN_W-1:0]  count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:     if (reqValid) nextState = reqWrite ? WR : RD_ISSUE;
`ifdef WRITE_VERIFY_EN
      WR:       nextState = VF_ISSUE;
      VF_ISSUE: nextState = VF_CHECK;
      VF_CHECK: nextState = IDLE;
`else
      WR:       nextState = IDLE;
`endif
      RD_ISSUE: nextState = RD_CAP;
      RD_CAP:   nextState = RSP;
      RSP:      if (rspReady) nextState = rspLast ? IDLE : RD_ISSUE;
      default:  nextState = IDLE;
    endcase
  end

  // data is only latched for writes so memIn holds its last written value
  // across reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr    <= '0;
      data    <= '0;
      count   <= '0;
      rspData <= '0;
      rspLast <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (reqValid) begin
            addr <= reqAddr;
            if (reqWrite) data  <= reqData;
            else          count <= reqLen;
          end
        end
        RD_CAP: begin
          rspData <= memOut;
          rspLast <= (count == '0);
        end
        RSP: begin
          if (rspReady && !rspLast) begin
            addr  <= addr + 1'b1;
            count <= count - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef WRITE_VERIFY_EN
  logic verifyErrReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   verifyErrReg <= 1'b0;
    else if (state == VF_CHECK && memOut != data) verifyErrReg <= 1'b1;
  end

  assign verifyErr = verifyErrReg;
  assign memRead   = (state == RD_ISSUE) || (state == VF_ISSUE);
`else
  assign verifyErr = 1'b0;
  assign memRead   = (state == RD_ISSUE);
`endif

  // Strobes decode from registered state so reset drops them asynchronously.
  assign memWrite   = (state == WR);
  assign lineNumber = addr;
  assign memIn      = data;
  assign rspValid   = (state == RSP);
  assign busy       = (state != IDLE);
  assign reqReady   = (state == IDLE) && rst_n;

endmodule

// File: tb/tb_data_mem_initiator.sv
module tb_data_mem_initiator;

`ifdef WRITE_VERIFY_EN
  localparam int WR_BUSY = 3;
`else
  localparam int WR_BUSY = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       reqValid, reqReady, reqWrite;
  logic [6:0] reqAddr;
  logic [7:0] reqData;
  logic [2:0] reqLen;
  logic       rspValid, rspReady, rspLast;
  logic [7:0] rspData;
  logic       busy, verifyErr;
  logic       memRead, memWrite;
  logic [6:0] lineNumber;
  logic [7:0] memIn, memOut;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [7:0] mem [128];
  logic [6:0] lineQ [$];
  int         rdPulses = 0;
  int         rspHs    = 0;
  logic       bothSeen = 1'b0;

  data_mem_initiator #(.ADDR_W(7), .DATA_W(8), .LEN_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqAddr(reqAddr), .reqData(reqData), .reqLen(reqLen),
    .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData),
    .rspLast(rspLast), .busy(busy), .verifyErr(verifyErr),
    .memRead(memRead), .memWrite(memWrite), .lineNumber(lineNumber),
    .memIn(memIn), .memOut(memOut)
  );

  always #5 clk = ~clk;

  // Memory stub: synchronous read, line 0x20 reads back corrupted.
  always @(posedge clk) begin
    if (memWrite) mem[lineNumber] <= memIn;
    if (memRead)  memOut <= mem[lineNumber] ^ ((lineNumber == 7'h20) ? 8'hFF : 8'h00);
  end

  always @(negedge clk) begin
    if (memRead) begin
      lineQ.push_back(lineNumber);
      rdPulses++;
    end
    if (memRead && memWrite) bothSeen = 1'b1;
  end

  always @(posedge clk) if (rspValid && rspReady) rspHs++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Returns #1 after the accept edge with reqValid dropped.
  task automatic sendReq(input logic w, input logic [6:0] a, input logic [7:0] d,
                         input logic [2:0] l);
    int n = 0;
    reqValid = 1'b1; reqWrite = w; reqAddr = a; reqData = d; reqLen = l;
    while (!reqReady && n < 50) begin tick; n++; end
    check("accept_timeout", 32'(n < 50), 1);
    tick;
    reqValid = 1'b0;
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    while (busy && n < 50) begin tick; n++; end
  endtask

  task automatic getBeat(output logic [7:0] d, output logic l);
    int n = 0;
    while (!rspValid && n < 50) begin tick; n++; end
    check("beat_timeout", 32'(n < 50), 1);
    d = rspData; l = rspLast;
    rspReady = 1'b1;
    tick;
    rspReady = 1'b0;
  endtask

  task automatic doWrite(input logic [6:0] a, input logic [7:0] d);
    int n;
    sendReq(1'b1, a, d, 3'd0);
    waitIdle(n);
  endtask

  initial begin
    logic [7:0] d;
    logic       l;
    logic       stable;
    int         n, hs0, rd0;

    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    rst_n = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0;
    reqData = '0; reqLen = '0; rspReady = 1'b0;

    // Reset state
    #3;
    check("rst_outs", {memRead, memWrite, lineNumber, memIn, rspValid, rspData,
                       rspLast, busy, verifyErr}, 0);
    check("rst_reqReady", reqReady, 0);
    tick; tick;
    rst_n = 1'b1;
    tick;
    check("reqReady_idle", reqReady, 1);

    // Write 0xA5 to 0x10
    sendReq(1'b1, 7'h10, 8'hA5, 3'd0);
    check("wr_memWrite", memWrite, 1);
    check("wr_line", lineNumber, 7'h10);
    check("wr_memIn", memIn, 8'hA5);
    check("wr_memRead", memRead, 0);
    waitIdle(n);
    check("wr_busy_cycles", n, WR_BUSY);
    check("wr_memWrite_drop", memWrite, 0);

    // Read 0x10 len 0: rspValid appears on the third edge after accept
    sendReq(1'b0, 7'h10, 8'h00, 3'd0);
    check("rd_lat_e1", rspValid, 0);
    tick;
    check("rd_lat_e2", rspValid, 0);
    tick;
    check("rd_lat_e3", rspValid, 1);
    check("rd_data", rspData, 8'hA5);
    check("rd_last", rspLast, 1);
    rspReady = 1'b1; tick; rspReady = 1'b0;
    check("rd_idle", busy, 0);

    // Burst across the wrap
    doWrite(7'd126, 8'h11);
    doWrite(7'd127, 8'h22);
    doWrite(7'd0,   8'h33);
    doWrite(7'd1,   8'h44);
    lineQ.delete();
    sendReq(1'b0, 7'd126, 8'h00, 3'd3);
    getBeat(d, l); check("burst_d0", {l, d}, {1'b0, 8'h11});
    getBeat(d, l); check("burst_d1", {l, d}, {1'b0, 8'h22});
    getBeat(d, l); check("burst_d2", {l, d}, {1'b0, 8'h33});
    getBeat(d, l); check("burst_d3", {l, d}, {1'b1, 8'h44});
    check("burst_nlines", lineQ.size(), 4);
    if (lineQ.size() == 4)
      check("burst_lines", {lineQ[0], lineQ[1], lineQ[2], lineQ[3]},
            {7'd126, 7'd127, 7'd0, 7'd1});
    check("burst_idle", busy, 0);

    // Backpressure on beat 1
    sendReq(1'b0, 7'd126, 8'h00, 3'd1);
    getBeat(d, l); check("bp_d0", {l, d}, {1'b0, 8'h11});
    n = 0;
    while (!rspValid && n < 50) begin tick; n++; end
    d = rspData; rd0 = rdPulses; stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (!rspValid || rspData !== d) stable = 1'b0;
    end
    check("bp_stable", stable, 1);
    check("bp_no_read", rdPulses - rd0, 0);
    getBeat(d, l); check("bp_d1", {l, d}, {1'b1, 8'h22});

    // Request held while busy; rspReady held high throughout
    rspReady = 1'b1;
    hs0 = rspHs;
    sendReq(1'b0, 7'd0, 8'h00, 3'd1);
    reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 7'd5; reqData = 8'h77;
    n = 0; stable = 1'b1;
    while (!reqReady && n < 50) begin
      if (!busy) stable = 1'b0;
      tick; n++;
    end
    check("busy_wait_cycles", n, 6);
    check("busy_ready_low", stable, 1);
    check("busy_beats", rspHs - hs0, 2);
    tick;
    reqValid = 1'b0;
    rspReady = 1'b0;
    check("held_wr", {memWrite, lineNumber, memIn}, {1'b1, 7'd5, 8'h77});
    waitIdle(n);

    // Reset during RSP of a burst
    sendReq(1'b0, 7'd126, 8'h00, 3'd3);
    n = 0;
    while (!rspValid && n < 50) begin tick; n++; end
    check("mid_rsp_reached", rspValid, 1);
    rst_n = 1'b0;
    #2;
    check("mid_rst_outs", {memRead, memWrite, lineNumber, memIn, rspValid, rspData,
                           rspLast, busy, verifyErr}, 0);
    tick; tick;
    rst_n = 1'b1;
    hs0 = rspHs; rd0 = rdPulses;
    rspReady = 1'b1;
    tick; tick; tick; tick;
    rspReady = 1'b0;
    check("post_rst_quiet", {busy, rspValid, 32'(rspHs - hs0), 32'(rdPulses - rd0)}, 0);
    sendReq(1'b0, 7'd5, 8'h00, 3'd0);
    getBeat(d, l); check("post_rst_read", {l, d}, {1'b1, 8'h77});

    // Write-verify flag
    doWrite(7'h20, 8'h5A);
`ifdef WRITE_VERIFY_EN
    check("vf_err_set", verifyErr, 1);
    doWrite(7'h21, 8'h01);
    check("vf_err_sticky", verifyErr, 1);
`else
    check("vf_err_off", verifyErr, 0);
    doWrite(7'h21, 8'h01);
    check("vf_err_off2", verifyErr, 0);
`endif

    check("rd_wr_exclusive", bothSeen, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
